// File: rtl/imem_fetch_port.sv
// Synchronous instruction memory with a valid/ready fetch port, LATENCY-deep read pipeline,
// run-time program load, misaligned/out-of-range fault flagging and pipeline flush.
module imem_fetch_port #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] FAULT_INSTR = 32'h0000_0013,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic [1:0]  resp_fault,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
  } stage_t;

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("imem_fetch_port: LATENCY must be in 1..3");
  end

  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("imem_fetch_port: DEPTH_WORDS must be a power of two, at least 4");
  end

  logic [31:0] mem [DEPTH_WORDS];
  stage_t      st  [LATENCY];

  logic          advance;
  logic          accept;
  logic          misaligned;
  logic          out_of_range;
  logic          wr_en;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [31:0]   rd_word;

  // Whole pipeline moves together; the output stage gates everything behind it.
  assign advance      = !st[LATENCY-1].valid || resp_ready;
  assign req_ready    = advance && !flush && !prog_we && !rst;
  assign accept       = req_valid && req_ready;

  assign misaligned   = req_addr[1:0] != 2'b00;
  assign out_of_range = {1'b0, req_addr} >= LIMIT;
  assign rd_idx       = req_addr[AW+1:2];
  assign rd_word      = mem[rd_idx];

  assign wr_idx       = prog_addr[AW+1:2];
  assign wr_en        = prog_we && !rst && (prog_addr[1:0] == 2'b00) && ({1'b0, prog_addr} < LIMIT);

  // Program-load port; storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= prog_data;
    end
  end

  // Read pipeline: lookup and fault decode in S1, later stages only delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        st[i] <= '{valid: 1'b0, addr: 32'h0, instr: FAULT_INSTR, fault: 2'b00};
      end
    end else if (flush) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        st[i].valid <= 1'b0;
      end
    end else if (advance) begin
      st[0].valid <= accept;
      if (accept) begin
        st[0].addr  <= req_addr;
        st[0].instr <= (misaligned || out_of_range) ? FAULT_INSTR : rd_word;
        st[0].fault <= {out_of_range, misaligned};
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        st[i] <= st[i-1];
      end
    end
  end

  assign resp_valid = st[LATENCY-1].valid;
  assign resp_addr  = st[LATENCY-1].addr;
  assign resp_instr = st[LATENCY-1].instr;
  assign resp_fault = st[LATENCY-1].fault;

endmodule
